// File: rtl/if_fetch_buf.sv
// Instruction fetch front end: issues sequential fetches under a credit limit,
// buffers in-order responses and presents one {addr, instr} pair to the core.
module if_fetch_buf #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000,
  parameter logic [DATA_W-1:0]  NOP      = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  input  logic              hold_n_i,
  input  logic              jmp_en_i,
  input  logic [ADDR_W-1:0] jmp_to_i,
  output logic              instr_valid_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] addr_instr_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 2;

  // Handshakes: a fetch transfers when imem_req_o & imem_gnt_i; the core takes
  // the head entry when instr_valid_o & hold_n_i; imem_rvalid_i carries one
  // word per cycle, in request order, and is never back-pressured.

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PW-1:0]     tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic [PW-1:0]     dat_wp_q, dat_wp_d, dat_rp_q, dat_rp_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     discard_q, discard_d;

  logic [ADDR_W-1:0] tag_mem_q   [DEPTH];
  logic [ADDR_W-1:0] dat_addr_q  [DEPTH];
  logic [DATA_W-1:0] dat_instr_q [DEPTH];

  logic [SW-1:0] credit_sum;
  logic          issue;
  logic          resp_drop;
  logic          resp_accept;
  logic          dat_push;
  logic          pop;
  logic          unused_jmp_bits;

  assign unused_jmp_bits = ^jmp_to_i[1:0];

  // Buffered entries, outstanding requests and pending discards share DEPTH
  // credits, so an accepted response always finds a free data slot.
  assign credit_sum  = SW'(fifo_cnt_q) + SW'(outst_q) + SW'(discard_q);
  assign imem_req_o  = !rst && !jmp_en_i && (credit_sum < SW'(DEPTH));
  assign imem_addr_o = pc_q;
  assign issue       = imem_req_o && imem_gnt_i;

  assign resp_drop   = imem_rvalid_i && (discard_q != '0);
  assign resp_accept = imem_rvalid_i && (discard_q == '0) && (outst_q != '0);
  assign dat_push    = resp_accept && !jmp_en_i;

  assign instr_valid_o = (fifo_cnt_q != '0);
  assign pop           = instr_valid_o && hold_n_i;
  assign instr_o       = instr_valid_o ? dat_instr_q[dat_rp_q] : NOP;
  assign addr_instr_o  = instr_valid_o ? dat_addr_q[dat_rp_q] : '0;

  always_comb begin
    pc_d       = pc_q;
    tag_wp_d   = tag_wp_q;
    tag_rp_d   = tag_rp_q;
    dat_wp_d   = dat_wp_q;
    dat_rp_d   = dat_rp_q;
    fifo_cnt_d = fifo_cnt_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    if (jmp_en_i) begin
      // Every request still in flight becomes a discard, minus the response
      // consumed by this very edge.
      pc_d       = {jmp_to_i[ADDR_W-1:2], 2'b00};
      tag_wp_d   = '0;
      tag_rp_d   = '0;
      dat_wp_d   = '0;
      dat_rp_d   = '0;
      fifo_cnt_d = '0;
      outst_d    = '0;
      discard_d  = discard_q + outst_q - CW'(resp_drop || resp_accept);
    end else begin
      if (issue) begin
        pc_d     = pc_q + ADDR_W'(4);
        tag_wp_d = tag_wp_q + PW'(1);
      end
      if (resp_drop) begin
        discard_d = discard_q - CW'(1);
      end
      if (resp_accept) begin
        tag_rp_d = tag_rp_q + PW'(1);
        dat_wp_d = dat_wp_q + PW'(1);
      end
      if (pop) begin
        dat_rp_d = dat_rp_q + PW'(1);
      end
      fifo_cnt_d = fifo_cnt_q + CW'(dat_push) - CW'(pop);
      outst_d    = outst_q + CW'(issue) - CW'(resp_accept);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      tag_wp_q   <= '0;
      tag_rp_q   <= '0;
      dat_wp_q   <= '0;
      dat_rp_q   <= '0;
      fifo_cnt_q <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      tag_wp_q   <= tag_wp_d;
      tag_rp_q   <= tag_rp_d;
      dat_wp_q   <= dat_wp_d;
      dat_rp_q   <= dat_rp_d;
      fifo_cnt_q <= fifo_cnt_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  // Storage needs no reset: the counters and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mem_q[tag_wp_q] <= pc_q;
    end
    if (dat_push) begin
      dat_addr_q[dat_wp_q]  <= tag_mem_q[tag_rp_q];
      dat_instr_q[dat_wp_q] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_if_fetch_buf.sv
// Bench for if_fetch_buf: directed phases plus random traffic, checked against
// a queue-based model of the fetch buffer and an in-order memory model.
module tb_if_fetch_buf;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        hold_n_i;
  logic        jmp_en_i;
  logic [31:0] jmp_to_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] addr_instr_o;

  if_fetch_buf #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH),
    .RESET_PC(32'h0000_0000), .NOP(NOP)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i), .hold_n_i(hold_n_i),
    .jmp_en_i(jmp_en_i), .jmp_to_i(jmp_to_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o),
    .addr_instr_o(addr_instr_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model state
  typedef struct { logic [31:0] addr; logic [31:0] instr; } pair_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  pair_t       m_data[$];
  logic [31:0] m_tags[$];
  int          m_disc;
  logic [31:0] m_pc;

  // memory model and logs
  mreq_t       mq[$];
  int          cyc;
  int          last_due;
  int          lat_min, lat_max, gnt_pct;
  int          grant_cnt;
  logic [31:0] issued_log[$];
  logic [31:0] deliv_log[$];

  int checks;
  int errors;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data.delete();
    m_tags.delete();
    m_disc   = 0;
    m_pc     = 32'h0000_0000;
    mq.delete();
    last_due = 0;
  endtask

  // driver: one clock cycle, entered and left at a falling edge
  task automatic run_cycle(input logic hold, input logic jmp, input logic [31:0] jto);
    logic        exp_req, exp_valid, resp, pop_en, dut_issue;
    logic [31:0] exp_instr, exp_addr, rdata;
    int          lat, due;
    hold_n_i      = hold;
    jmp_en_i      = jmp;
    jmp_to_i      = jto;
    imem_gnt_i    = ($urandom_range(99, 0) < gnt_pct);
    resp          = (mq.size() > 0) && (mq[0].due <= cyc);
    rdata         = resp ? mem_word(mq[0].addr) : $urandom;
    imem_rvalid_i = resp;
    imem_rdata_i  = rdata;
    #1;
    exp_req   = !jmp && ((m_data.size() + m_tags.size() + m_disc) < DEPTH);
    exp_valid = (m_data.size() > 0);
    exp_instr = exp_valid ? m_data[0].instr : NOP;
    exp_addr  = exp_valid ? m_data[0].addr : 32'h0;
    chk("imem_req", 32'(imem_req_o), 32'(exp_req));
    chk("imem_addr", imem_addr_o, m_pc);
    chk("instr_valid", 32'(instr_valid_o), 32'(exp_valid));
    chk("instr", instr_o, exp_instr);
    chk("addr_instr", addr_instr_o, exp_addr);

    dut_issue = imem_req_o && imem_gnt_i;
    if (dut_issue) begin
      grant_cnt++;
      issued_log.push_back(imem_addr_o);
    end
    if (instr_valid_o && hold) deliv_log.push_back(addr_instr_o);

    pop_en = exp_valid && hold;
    if (jmp) begin
      m_disc = m_disc + m_tags.size() - ((resp && (m_disc > 0 || m_tags.size() > 0)) ? 1 : 0);
      m_tags.delete();
      m_data.delete();
      m_pc = {jto[31:2], 2'b00};
    end else begin
      if (pop_en) void'(m_data.pop_front());
      if (resp) begin
        if (m_disc > 0) m_disc--;
        else if (m_tags.size() > 0) m_data.push_back('{addr: m_tags.pop_front(), instr: rdata});
      end
      if (exp_req && imem_gnt_i) begin
        m_tags.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end

    if (resp) void'(mq.pop_front());
    if (dut_issue) begin
      lat = $urandom_range(lat_max, lat_min);
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      mq.push_back('{addr: imem_addr_o, due: due});
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int g0;
    checks = 0; errors = 0; cyc = 0; grant_cnt = 0;
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    rst = 1'b1;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    hold_n_i = 1'b1; jmp_en_i = 1'b0; jmp_to_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, NOP);
    chk("rst_addr_instr", addr_instr_o, 32'h0);
    rst = 1'b0;

    // stream: grant every cycle, 1-cycle latency
    issued_log.delete(); deliv_log.delete();
    for (int i = 0; i < 12; i++) run_cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) chk("stream_issue", issued_log[i], 32'(4 * i));
    chk("stream_first_deliv", deliv_log[0], 32'h0);

    // asynchronous reset between clock edges
    #2 rst = 1'b1;
    imem_rvalid_i = 1'b0;
    #1;
    chk("arst_valid", 32'(instr_valid_o), 32'd0);
    chk("arst_req", 32'(imem_req_o), 32'd0);
    chk("arst_instr", instr_o, NOP);
    chk("arst_addr", imem_addr_o, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // back-pressure from empty
    g0 = grant_cnt;
    issued_log.delete(); deliv_log.delete();
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b0, '0);
    chk("bp_grants", 32'(grant_cnt - g0), 32'd4);
    chk("bp_req_stopped", 32'(imem_req_o), 32'd0);
    for (int i = 0; i < 6; i++) run_cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) chk("bp_deliv", deliv_log[i], 32'(4 * i));
    chk("bp_resume", issued_log[4], 32'h10);

    // flush with requests in flight, 3-cycle memory
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b0, '0);
    run_cycle(1'b1, 1'b1, 32'h0000_0102);
    issued_log.delete(); deliv_log.delete();
    for (int i = 0; i < 12; i++) run_cycle(1'b1, 1'b0, '0);
    chk("flush_issue", issued_log[0], 32'h100);
    chk("flush_deliv", deliv_log[0], 32'h100);

    // wrap, jumping during a full-rate stream (rvalid and pop in the flush cycle)
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 6; i++) run_cycle(1'b1, 1'b0, '0);
    run_cycle(1'b1, 1'b1, 32'hFFFF_FFFB);
    issued_log.delete();
    for (int i = 0; i < 6; i++) run_cycle(1'b1, 1'b0, '0);
    chk("wrap0", issued_log[0], 32'hFFFF_FFF8);
    chk("wrap1", issued_log[1], 32'hFFFF_FFFC);
    chk("wrap2", issued_log[2], 32'h0000_0000);

    // random traffic
    lat_min = 1; lat_max = 4; gnt_pct = 70;
    for (int i = 0; i < 600; i++) begin
      run_cycle($urandom_range(3, 0) != 0, $urandom_range(19, 0) == 0, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
